input_skew_buffer: RTL and testbench
====================================

INPUT_SKEW_BUFFER -- requirements
Module: input_skew_buffer

Interface
REQ-001 Parameter ROW_COUNT, default 4, number of router lanes and array rows.
REQ-002 Parameter DATA_WIDTH, default 8, bits per lane element.
REQ-003 Parameter FIFO_DEPTH, default 8, entries per lane FIFO (power of two, >=4).
REQ-004 i_clk  input  1  single clock; all state on rising edge.
REQ-005 i_rst  input  1  reset, asynchronous, active-high.
REQ-006 i_en  input  1  block enable; when low, no pops and no skew shifts; writes still accepted.
REQ-007 i_reg_clear  input  1  synchronous clear of all state.
REQ-008 i_data  input  ROW_COUNT x DATA_WIDTH  lane data from input router.
REQ-009 i_data_valid  input  ROW_COUNT  per-lane write strobe.
REQ-010 i_flush  input  1  context done; drain remaining entries.
REQ-011 i_stall  input  1  array back-pressure; freezes pops and skew pipeline.
REQ-012 o_pop_en  output  1  upstream credit: router may emit next element.
REQ-013 o_data  output  ROW_COUNT x DATA_WIDTH  skewed data to PE array rows.
REQ-014 o_data_valid  output  ROW_COUNT  per-row valid.
REQ-015 o_empty  output  1  all FIFOs and skew stages empty.
REQ-016 o_drain_done  output  1  one-cycle pulse at end of drain.
REQ-017 o_overflow  output  1  sticky write-to-full flag.

Function
REQ-018 Each lane SHALL own a FIFO; i_data_valid[r] writes i_data[r] into lane r in the same cycle.
REQ-019 o_pop_en SHALL be high when i_en is high and every lane has >=2 free slots (counts from registers, combinational output).
REQ-020 States SHALL be IDLE, STREAM, DRAIN; reset/clear enters IDLE.
REQ-021 IDLE->STREAM when any lane is non-empty and i_en=1; STREAM->IDLE when all lanes and skew stages empty and i_flush=0.
REQ-022 In STREAM, a wavefront pop SHALL occur in a cycle iff every lane is non-empty, i_en=1, i_stall=0; one entry popped from every lane simultaneously.
REQ-023 Any state ->DRAIN on i_flush=1 (priority over STREAM transitions); in DRAIN, pop every non-empty lane when i_en=1 and i_stall=0; empty lanes inject valid=0.
REQ-024 DRAIN->IDLE when all FIFOs and all skew stages empty; o_drain_done pulses in the cycle of that transition.
REQ-025 Popped lane-r element SHALL reach o_data[r] exactly 1+r enabled, unstalled cycles after the pop (lane 0 latency 1, lane ROW_COUNT-1 latency ROW_COUNT).
REQ-026 Skew stages SHALL carry valid with data; when i_stall=1 or i_en=0 all stages and outputs hold.
REQ-027 Simultaneous write and pop on a full lane SHALL succeed with count unchanged.
REQ-028 Write to a full lane without pop SHALL be dropped; FIFO contents unchanged.
REQ-029 Pointers SHALL wrap modulo FIFO_DEPTH; count width clog2(FIFO_DEPTH)+1.
REQ-030 i_reg_clear SHALL have priority over all writes, pops and transitions.

Reset
REQ-031 On i_rst=1 (asynchronous) or i_reg_clear=1 (synchronous): FIFOs empty, skew stages invalid, state IDLE, o_data=0, o_data_valid=0, o_empty=1, o_drain_done=0, o_overflow=0, o_pop_en=0 during reset.
REQ-032 Reset asserted mid-stream SHALL discard all in-flight data; no valid output until new writes arrive.

Configuration
REQ-033 Macro INPUT_SKEW_OVF_CHECK_EN defined: o_overflow sets on any REQ-028 drop, held until reset/clear.
REQ-034 Macro undefined: o_overflow tied 0; drop behaviour of REQ-028 unchanged.

Structure
REQ-035 Package isb_pkg SHALL hold the state enum (IDLE, STREAM, DRAIN) and the minimum-free-slot constant (2).
REQ-036 Per-lane storage SHALL be sub-module isb_lane_fifo, instantiated ROW_COUNT times; skew pipeline and FSM in top.

Verification
REQ-037 Write lanes 0..3 with 0x10,0x20,0x30,0x40 in one cycle -> o_data[0]=0x10 at t+2, [1]=0x20 at t+3, [2]=0x30 at t+4, [3]=0x40 at t+5 (write cycle t, pop cycle t+1).
REQ-038 Lanes 0-2 written, lane 3 empty -> no pop, o_data_valid=0; write lane 3 -> wavefront emitted per REQ-025.
REQ-039 Fill lane 0 to 8 entries, write again -> entry dropped, o_overflow=1 (macro defined) / 0 (undefined), o_pop_en=0 from 7 entries on.
REQ-040 Stream, assert i_stall 3 cycles -> outputs frozen 3 cycles, no data lost or duplicated.
REQ-041 Lanes hold 2,1,0,3 entries, pulse i_flush -> all 6 elements emitted with skew, o_drain_done pulses once, o_empty=1 after.
REQ-042 Assert i_rst mid-stream with 4 entries per lane -> all outputs zero immediately, o_empty=1, no stale data after release.

Source files
------------

// File: rtl/isb_pkg.sv
// Shared types and constants for the input skew buffer.
package isb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DRAIN  = 2'd2
  } state_t;

  // Free slots every lane must keep before the router is granted another element
  localparam int unsigned MIN_FREE_SLOTS = 2;

endpackage

// File: rtl/input_skew_buffer_if.sv
// Router-side and array-side signal bundle of the input skew buffer.
interface input_skew_buffer_if #(
  parameter int unsigned ROW_COUNT  = 4,
  parameter int unsigned DATA_WIDTH = 8
);

  logic                                 i_en;
  logic                                 i_reg_clear;
  logic [ROW_COUNT-1:0][DATA_WIDTH-1:0] i_data;
  logic [ROW_COUNT-1:0]                 i_data_valid;
  logic                                 i_flush;
  logic                                 i_stall;
  logic                                 o_pop_en;
  logic [ROW_COUNT-1:0][DATA_WIDTH-1:0] o_data;
  logic [ROW_COUNT-1:0]                 o_data_valid;
  logic                                 o_empty;
  logic                                 o_drain_done;
  logic                                 o_overflow;

  modport master (
    output i_en, i_reg_clear, i_data, i_data_valid, i_flush, i_stall,
    input  o_pop_en, o_data, o_data_valid, o_empty, o_drain_done, o_overflow
  );

  modport slave (
    input  i_en, i_reg_clear, i_data, i_data_valid, i_flush, i_stall,
    output o_pop_en, o_data, o_data_valid, o_empty, o_drain_done, o_overflow
  );

endinterface

// File: rtl/isb_lane_fifo.sv
// Single-lane FIFO of the skew buffer; reports emptiness, credit room and dropped writes.
module isb_lane_fifo
  import isb_pkg::*;
#(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             wr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd,
  output logic [WIDTH-1:0] rd_data,
  output logic             empty,
  output logic             has_room,
  output logic             drop
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             full;
  logic             do_rd;
  logic             do_wr;

  assign empty    = (cnt == '0);
  assign full     = (cnt == CW'(DEPTH));
  assign has_room = (cnt <= CW'(DEPTH - MIN_FREE_SLOTS));
  assign do_rd    = rd && !empty && !clear;
  // A pop in the same cycle frees the slot a write to a full lane needs
  assign do_wr    = wr && !clear && (!full || do_rd);
  assign drop     = wr && !clear && full && !do_rd;
  assign rd_data  = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + AW'(1);
      if (do_rd) rd_ptr <= rd_ptr + AW'(1);
      if (do_wr && !do_rd)      cnt <= cnt + CW'(1);
      else if (do_rd && !do_wr) cnt <= cnt - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/input_skew_buffer.sv
// Per-lane FIFOs feeding a triangular skew pipeline into the PE array rows.
// Define INPUT_SKEW_OVF_CHECK_EN to enable the sticky overflow flag.
module input_skew_buffer
  import isb_pkg::*;
#(
  parameter int unsigned ROW_COUNT  = 4,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input logic                i_clk,
  input logic                i_rst,
  input_skew_buffer_if.slave bus
);

  state_t state_q;
  state_t state_d;

  logic [ROW_COUNT-1:0]                 lane_empty;
  logic [ROW_COUNT-1:0]                 lane_room;
  logic [ROW_COUNT-1:0]                 lane_drop;
  logic [ROW_COUNT-1:0]                 lane_rd;
  logic [ROW_COUNT-1:0][DATA_WIDTH-1:0] lane_q;
  wire  [ROW_COUNT-1:0]                 stage_busy;
  wire  [ROW_COUNT-1:0]                 out_vld;
  wire  [ROW_COUNT-1:0][DATA_WIDTH-1:0] out_dat;

  logic shift;
  logic fifos_empty;
  logic all_empty;
  logic drain_done_c;

  assign shift       = bus.i_en && !bus.i_stall;
  assign fifos_empty = &lane_empty;
  assign all_empty   = fifos_empty && !(|stage_busy);

  // Wavefront pops need every lane populated; drain pops whatever is left
  always_comb begin
    lane_rd = '0;
    if (shift) begin
      if (state_q == DRAIN) lane_rd = ~lane_empty;
      else if (!(|lane_empty)) lane_rd = '1;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)                state_q <= IDLE;
    else if (bus.i_reg_clear) state_q <= IDLE;
    else                      state_q <= state_d;
  end

  always_comb begin
    state_d      = state_q;
    drain_done_c = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.i_flush)                     state_d = DRAIN;
        else if (!fifos_empty && bus.i_en)   state_d = STREAM;
      end
      STREAM: begin
        if (bus.i_flush)    state_d = DRAIN;
        else if (all_empty) state_d = IDLE;
      end
      DRAIN: begin
        if (all_empty) begin
          state_d      = IDLE;
          drain_done_c = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  for (genvar r = 0; r < ROW_COUNT; r++) begin : g_lane
    logic [r:0]                 vld;
    logic [r:0][DATA_WIDTH-1:0] dat;

    isb_lane_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (DATA_WIDTH)
    ) u_fifo (
      .clk      (i_clk),
      .rst      (i_rst),
      .clear    (bus.i_reg_clear),
      .wr       (bus.i_data_valid[r]),
      .wr_data  (bus.i_data[r]),
      .rd       (lane_rd[r]),
      .rd_data  (lane_q[r]),
      .empty    (lane_empty[r]),
      .has_room (lane_room[r]),
      .drop     (lane_drop[r])
    );

    // Lane r sees r+1 stages, so row r lags row 0 by r cycles
    always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
        vld <= '0;
        dat <= '0;
      end else if (bus.i_reg_clear) begin
        vld <= '0;
        dat <= '0;
      end else if (shift) begin
        vld[0] <= lane_rd[r];
        dat[0] <= lane_rd[r] ? lane_q[r] : '0;
        for (int s = int'(r); s > 0; s--) begin
          vld[s] <= vld[s-1];
          dat[s] <= dat[s-1];
        end
      end
    end

    assign stage_busy[r] = |vld;
    assign out_vld[r]    = vld[r];
    assign out_dat[r]    = dat[r];
  end

`ifdef INPUT_SKEW_OVF_CHECK_EN
  logic ovf_q;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)                ovf_q <= 1'b0;
    else if (bus.i_reg_clear) ovf_q <= 1'b0;
    else if (|lane_drop)      ovf_q <= 1'b1;
  end

  assign bus.o_overflow = ovf_q;
`else
  logic unused_drop;
  assign unused_drop    = ^lane_drop;
  assign bus.o_overflow = 1'b0;
`endif

  assign bus.o_pop_en     = bus.i_en && (&lane_room) && !i_rst && !bus.i_reg_clear;
  assign bus.o_data       = out_dat;
  assign bus.o_data_valid = out_vld;
  assign bus.o_empty      = all_empty;
  assign bus.o_drain_done = drain_done_c && !bus.i_reg_clear && !i_rst;

endmodule

// File: tb/tb_input_skew_buffer.sv
// Directed self-checking bench for input_skew_buffer (4 rows, 8-bit, depth 8).
module tb_input_skew_buffer;

  localparam int unsigned ROWS  = 4;
  localparam int unsigned DW    = 8;
  localparam int unsigned DEPTH = 8;
`ifdef INPUT_SKEW_OVF_CHECK_EN
  localparam bit OVF_EXP = 1'b1;
`else
  localparam bit OVF_EXP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  input_skew_buffer_if #(.ROW_COUNT(ROWS), .DATA_WIDTH(DW)) bus ();

  input_skew_buffer #(
    .ROW_COUNT  (ROWS),
    .DATA_WIDTH (DW),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    bus.i_en = 1'b1; bus.i_reg_clear = 1'b0; bus.i_flush = 1'b0; bus.i_stall = 1'b0;
    bus.i_data = '0; bus.i_data_valid = '0;
    rst = 1'b1;
    #2;
    checks++; if (bus.o_pop_en !== 1'b0) begin errors++; $display("FAIL reset_pop_en: got %b want 0", bus.o_pop_en); end
    checks++; if (bus.o_empty !== 1'b1) begin errors++; $display("FAIL reset_empty: got %b want 1", bus.o_empty); end
    checks++; if (bus.o_data_valid !== 4'b0) begin errors++; $display("FAIL reset_valid: got %b want 0000", bus.o_data_valid); end
    checks++; if (bus.o_data !== 32'h0) begin errors++; $display("FAIL reset_data: got %h want 0", bus.o_data); end
    checks++; if (bus.o_drain_done !== 1'b0) begin errors++; $display("FAIL reset_drain_done: got %b want 0", bus.o_drain_done); end
    checks++; if (bus.o_overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %b want 0", bus.o_overflow); end
    tick(); tick();
    rst = 1'b0;
    tick();
    checks++; if (bus.o_pop_en !== 1'b1) begin errors++; $display("FAIL post_reset_pop_en: got %b want 1", bus.o_pop_en); end
  endtask

  task automatic test_wavefront();
    logic [ROWS-1:0][DW-1:0] vec;
    logic [ROWS-1:0][DW-1:0] exp_d;
    logic [ROWS-1:0]         exp_v;
    vec = {8'h40, 8'h30, 8'h20, 8'h10};
    bus.i_data = vec; bus.i_data_valid = 4'b1111;
    tick();
    bus.i_data_valid = '0;
    checks++; if (bus.o_data_valid !== 4'b0) begin errors++; $display("FAIL wave_pop_cycle: got %b want 0000", bus.o_data_valid); end
    for (int k = 0; k < 4; k++) begin
      tick();
      exp_v = 4'(1 << k);
      exp_d = '0; exp_d[k] = vec[k];
      checks++; if (bus.o_data_valid !== exp_v) begin errors++; $display("FAIL wave_valid t+%0d: got %b want %b", k + 2, bus.o_data_valid, exp_v); end
      checks++; if (bus.o_data !== exp_d) begin errors++; $display("FAIL wave_data t+%0d: got %h want %h", k + 2, bus.o_data, exp_d); end
    end
    tick();
    checks++; if (bus.o_data_valid !== 4'b0) begin errors++; $display("FAIL wave_tail_valid: got %b want 0000", bus.o_data_valid); end
    checks++; if (bus.o_empty !== 1'b1) begin errors++; $display("FAIL wave_empty: got %b want 1", bus.o_empty); end
  endtask

  task automatic test_partial();
    logic [ROWS-1:0][DW-1:0] vec;
    logic [ROWS-1:0][DW-1:0] exp_d;
    logic [ROWS-1:0]         exp_v;
    vec = {8'h44, 8'h33, 8'h22, 8'h11};
    bus.i_data = vec; bus.i_data_valid = 4'b0111;
    tick();
    bus.i_data_valid = '0;
    for (int c = 0; c < 4; c++) begin
      checks++; if (bus.o_data_valid !== 4'b0) begin errors++; $display("FAIL partial_hold c=%0d: got %b want 0000", c, bus.o_data_valid); end
      tick();
    end
    bus.i_data_valid = 4'b1000;
    tick();
    bus.i_data_valid = '0;
    for (int k = 0; k < 4; k++) begin
      tick();
      exp_v = 4'(1 << k);
      exp_d = '0; exp_d[k] = vec[k];
      checks++; if (bus.o_data_valid !== exp_v) begin errors++; $display("FAIL partial_valid k=%0d: got %b want %b", k, bus.o_data_valid, exp_v); end
      checks++; if (bus.o_data !== exp_d) begin errors++; $display("FAIL partial_data k=%0d: got %h want %h", k, bus.o_data, exp_d); end
    end
    tick();
  endtask

  task automatic test_stall();
    logic [ROWS-1:0][DW-1:0] exp_d;
    logic [ROWS-1:0]         exp_v;
    int e;
    int k;
    for (int c = 0; c < 12; c++) begin
      bus.i_data_valid = (c < 3) ? 4'b1111 : 4'b0000;
      for (int r = 0; r < 4; r++) bus.i_data[r] = 8'(r * 16 + c + 1);
      bus.i_stall = (c >= 4 && c <= 6);
      if (c >= 1) begin
        e = (c <= 4) ? c : ((c < 8) ? 4 : c - 3);
        exp_v = '0; exp_d = '0;
        for (int r = 0; r < 4; r++) begin
          k = e - 1 - r;
          if (k >= 1 && k <= 3) begin
            exp_v[r] = 1'b1;
            exp_d[r] = 8'(r * 16 + k);
          end
        end
        checks++; if (bus.o_data_valid !== exp_v) begin errors++; $display("FAIL stall_valid c=%0d: got %b want %b", c, bus.o_data_valid, exp_v); end
        checks++; if (bus.o_data !== exp_d) begin errors++; $display("FAIL stall_data c=%0d: got %h want %h", c, bus.o_data, exp_d); end
      end
      tick();
    end
    bus.i_stall = 1'b0; bus.i_data_valid = '0;
  endtask

  task automatic test_drain();
    logic [3:0]  ev [1:10];
    logic [31:0] ed [1:10];
    ev = '{4'b0000, 4'b0001, 4'b0011, 4'b0000, 4'b1000, 4'b1000, 4'b1000, 4'b0000, 4'b0000, 4'b0000};
    ed = '{32'h0, 32'h0000_00A0, 32'h0000_B0A1, 32'h0, 32'hD000_0000, 32'hD100_0000, 32'hD200_0000,
           32'h0, 32'h0, 32'h0};
    bus.i_data = {8'hD0, 8'h00, 8'hB0, 8'hA0}; bus.i_data_valid = 4'b1011;
    tick();
    bus.i_data = {8'hD1, 8'h00, 8'h00, 8'hA1}; bus.i_data_valid = 4'b1001;
    tick();
    bus.i_data = {8'hD2, 8'h00, 8'h00, 8'h00}; bus.i_data_valid = 4'b1000;
    tick();
    bus.i_data_valid = '0; bus.i_flush = 1'b1;
    tick();
    bus.i_flush = 1'b0;
    for (int d = 1; d <= 10; d++) begin
      checks++; if (bus.o_data_valid !== ev[d]) begin errors++; $display("FAIL drain_valid d=%0d: got %b want %b", d, bus.o_data_valid, ev[d]); end
      checks++; if (bus.o_data !== ed[d]) begin errors++; $display("FAIL drain_data d=%0d: got %h want %h", d, bus.o_data, ed[d]); end
      checks++; if (bus.o_drain_done !== (d == 8)) begin errors++; $display("FAIL drain_done d=%0d: got %b want %b", d, bus.o_drain_done, (d == 8)); end
      tick();
    end
    checks++; if (bus.o_empty !== 1'b1) begin errors++; $display("FAIL drain_empty: got %b want 1", bus.o_empty); end
  endtask

  task automatic test_overflow();
    logic [DW-1:0] got [16];
    int n;
    int done_n;
    n = 0; done_n = 0;
    for (int i = 0; i < 8; i++) begin
      bus.i_data = '0; bus.i_data[0] = 8'(8'h80 + i); bus.i_data_valid = 4'b0001;
      tick();
      checks++; if (bus.o_pop_en !== (i + 1 <= 6)) begin errors++; $display("FAIL ovf_pop_en cnt=%0d: got %b want %b", i + 1, bus.o_pop_en, (i + 1 <= 6)); end
    end
    bus.i_data[0] = 8'h99;
    tick();
    bus.i_data_valid = '0;
    checks++; if (bus.o_overflow !== OVF_EXP) begin errors++; $display("FAIL ovf_flag: got %b want %b", bus.o_overflow, OVF_EXP); end
    checks++; if (bus.o_pop_en !== 1'b0) begin errors++; $display("FAIL ovf_full_pop_en: got %b want 0", bus.o_pop_en); end
    bus.i_flush = 1'b1;
    tick();
    bus.i_flush = 1'b0;
    for (int c = 0; c < 20; c++) begin
      if (bus.o_data_valid[0] === 1'b1 && n < 16) begin got[n] = bus.o_data[0]; n++; end
      if (bus.o_drain_done === 1'b1) done_n++;
      tick();
    end
    checks++; if (n !== 8) begin errors++; $display("FAIL ovf_drain_count: got %0d want 8", n); end
    for (int j = 0; j < 8; j++) begin
      checks++; if (j >= n || got[j] !== 8'(8'h80 + j)) begin errors++; $display("FAIL ovf_drain_data j=%0d: got %h want %h", j, (j < n) ? got[j] : 8'hxx, 8'(8'h80 + j)); end
    end
    checks++; if (done_n !== 1) begin errors++; $display("FAIL ovf_drain_done_pulses: got %0d want 1", done_n); end
    checks++; if (bus.o_overflow !== OVF_EXP) begin errors++; $display("FAIL ovf_sticky: got %b want %b", bus.o_overflow, OVF_EXP); end
    bus.i_reg_clear = 1'b1;
    tick();
    bus.i_reg_clear = 1'b0;
    checks++; if (bus.o_overflow !== 1'b0) begin errors++; $display("FAIL ovf_clear: got %b want 0", bus.o_overflow); end
    checks++; if (bus.o_empty !== 1'b1) begin errors++; $display("FAIL clear_empty: got %b want 1", bus.o_empty); end
  endtask

  task automatic test_reset_midstream();
    for (int c = 0; c < 6; c++) begin
      bus.i_data_valid = (c < 4) ? 4'b1111 : 4'b0000;
      for (int r = 0; r < 4; r++) bus.i_data[r] = 8'(8'h60 + r * 16 + c);
      bus.i_stall = (c < 4);
      tick();
    end
    checks++; if (bus.o_data_valid !== 4'b0011) begin errors++; $display("FAIL mid_valid: got %b want 0011", bus.o_data_valid); end
    checks++; if (bus.o_data !== 32'h0000_7061) begin errors++; $display("FAIL mid_data: got %h want 00007061", bus.o_data); end
    #2;
    rst = 1'b1;
    #1;
    checks++; if (bus.o_data_valid !== 4'b0) begin errors++; $display("FAIL rst_mid_valid: got %b want 0000", bus.o_data_valid); end
    checks++; if (bus.o_data !== 32'h0) begin errors++; $display("FAIL rst_mid_data: got %h want 0", bus.o_data); end
    checks++; if (bus.o_empty !== 1'b1) begin errors++; $display("FAIL rst_mid_empty: got %b want 1", bus.o_empty); end
    checks++; if (bus.o_pop_en !== 1'b0) begin errors++; $display("FAIL rst_mid_pop_en: got %b want 0", bus.o_pop_en); end
    tick();
    rst = 1'b0;
    for (int c = 0; c < 6; c++) begin
      tick();
      checks++; if (bus.o_data_valid !== 4'b0) begin errors++; $display("FAIL rst_stale c=%0d: got %b want 0000", c, bus.o_data_valid); end
    end
    bus.i_data = {8'hE3, 8'hE2, 8'hE1, 8'hE0}; bus.i_data_valid = 4'b1111;
    tick();
    bus.i_data_valid = '0;
    tick();
    checks++; if (bus.o_data_valid !== 4'b0001) begin errors++; $display("FAIL rst_new_valid: got %b want 0001", bus.o_data_valid); end
    checks++; if (bus.o_data !== 32'h0000_00E0) begin errors++; $display("FAIL rst_new_data: got %h want 000000e0", bus.o_data); end
  endtask

  initial begin
    test_reset();
    test_wavefront();
    test_partial();
    test_stall();
    test_drain();
    test_overflow();
    test_reset_midstream();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
